// File: rtl/device1_tx_frame_controller_pkg.sv
// Shared types and helpers for the device1 UART transmit frame controller.
package uart_tx_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int MIN_DATA_W  = 5;
    localparam int MAX_CHAR_W  = 8;

    // Legal character widths are 5..8; anything outside is pulled to the nearest bound.
    function automatic logic [3:0] clamp_width(input logic [3:0] width);
        if (width < 4'(MIN_DATA_W)) begin
            return 4'(MIN_DATA_W);
        end else if (width > 4'(MAX_CHAR_W)) begin
            return 4'(MAX_CHAR_W);
        end else begin
            return width;
        end
    endfunction

endpackage

// File: rtl/device1_tx_frame_controller_if.sv
// Character handshake between the driver BFM layer and the transmit frame controller.
interface device1_tx_frame_controller_if #(
    parameter int MAX_DATA_W = 8
) ();
    logic                  tx_valid;
    logic                  tx_ready;
    logic [MAX_DATA_W-1:0] tx_data;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/device1_tx_frame_controller_baud_timer.sv
// Loadable down-counter that times one serial bit; bit_end marks the final clock of a bit.
module uart_baud_timer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] load_val,
    output logic                 bit_end
);

    logic [DIV_WIDTH-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - DIV_WIDTH'(1);
        end
    end

    assign bit_end = (cnt_reg == '0);

endmodule

// File: rtl/device1_tx_frame_controller.sv
// Serializes one character per handshake onto the device1 UART tx line as
// start / 5..8 data / optional parity / 1..2 stop bits, each bit timed by a baud divisor.
module device1_tx_frame_controller
    import uart_tx_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH  = 16,
    parameter int MAX_DATA_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DIV_WIDTH-1:0]         cfg_baud_div,
    input  logic [3:0]                   cfg_data_width,
    input  logic                         cfg_parity_en,
    input  logic                         cfg_parity_odd,
    input  logic                         cfg_stop2,
    device1_tx_frame_controller_if.slave char_if,
    output logic                         tx,
    output logic                         busy,
    output logic                         frame_done
);

    tx_state_e             state_reg;
    tx_state_e             state_next;
    logic [MAX_DATA_W-1:0] data_reg;
    logic [MAX_DATA_W-1:0] data_masked;
    logic [3:0]            width_reg;
    logic [3:0]            accept_width;
    logic                  par_en_reg;
    logic                  par_odd_reg;
    logic                  stop2_reg;
    logic [DIV_WIDTH-1:0]  div_reg;
    logic [DIV_WIDTH-1:0]  accept_div;
    logic [DIV_WIDTH-1:0]  baud_load_val;
    logic [2:0]            bit_cnt_reg;
    logic [2:0]            bit_cnt_next;
    logic                  stop_cnt_reg;
    logic                  stop_cnt_next;
    logic                  tx_reg;
    logic                  tx_next;
    logic                  bit_end;
    logic                  baud_load;
    logic                  ready;
    logic                  accept;
    logic                  last_data_bit;
    logic                  last_stop_bit;
    logic                  parity_bit;

    assign accept_width = clamp_width(cfg_data_width);
    assign accept_div   = (cfg_baud_div == '0) ? DIV_WIDTH'(1) : cfg_baud_div;

    // Bits above the accepted width are cleared at latch time so parity can reduce the whole register.
    generate
        for (genvar gi = 0; gi < MAX_DATA_W; gi++) begin : g_mask
            assign data_masked[gi] = char_if.tx_data[gi] & (accept_width > 4'(gi));
        end
    endgenerate

    assign parity_bit    = (^data_reg) ^ par_odd_reg;
    assign last_data_bit = ({1'b0, bit_cnt_reg} == (width_reg - 4'd1));
    assign last_stop_bit = (stop_cnt_reg == stop2_reg);

    // Ready also on the final stop-bit clock so a waiting character follows with no idle gap.
    assign ready  = (state_reg == IDLE) || ((state_reg == STOP) && bit_end && last_stop_bit);
    assign accept = char_if.tx_valid && ready;

    assign baud_load     = accept || ((state_reg != IDLE) && bit_end);
    assign baud_load_val = accept ? (accept_div - DIV_WIDTH'(1)) : (div_reg - DIV_WIDTH'(1));

    uart_baud_timer #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (baud_load),
        .load_val (baud_load_val),
        .bit_end  (bit_end)
    );

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        tx_next       = tx_reg;
        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (accept) begin
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_cnt_next = 3'd0;
                    tx_next      = data_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (last_data_bit) begin
                        if (par_en_reg) begin
                            state_next = PARITY;
                            tx_next    = parity_bit;
                        end else begin
                            state_next    = STOP;
                            stop_cnt_next = 1'b0;
                            tx_next       = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        tx_next      = data_reg[bit_cnt_next];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next    = STOP;
                    stop_cnt_next = 1'b0;
                    tx_next       = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (last_stop_bit) begin
                        if (accept) begin
                            state_next = START;
                            tx_next    = 1'b0;
                        end else begin
                            state_next = IDLE;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        stop_cnt_next = 1'b1;
                        tx_next       = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            tx_reg       <= 1'b1;
            bit_cnt_reg  <= 3'd0;
            stop_cnt_reg <= 1'b0;
            data_reg     <= '0;
            width_reg    <= 4'(MIN_DATA_W);
            par_en_reg   <= 1'b0;
            par_odd_reg  <= 1'b0;
            stop2_reg    <= 1'b0;
            div_reg      <= DIV_WIDTH'(1);
        end else begin
            state_reg    <= state_next;
            tx_reg       <= tx_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            // Frame configuration is frozen here; later cfg changes wait for the next character.
            if (accept) begin
                data_reg    <= data_masked;
                width_reg   <= accept_width;
                par_en_reg  <= cfg_parity_en;
                par_odd_reg <= cfg_parity_odd;
                stop2_reg   <= cfg_stop2;
                div_reg     <= accept_div;
            end
        end
    end

    assign tx               = tx_reg;
    assign busy             = (state_reg != IDLE);
    assign frame_done       = (state_reg == STOP) && bit_end && last_stop_bit;
    assign char_if.tx_ready = ready;

endmodule

// File: tb/tb_device1_tx_frame_controller.sv
// Directed and randomized checks of the device1 UART transmit frame controller against a line-level model.
module tb_device1_tx_frame_controller;

    localparam int DIV_WIDTH  = 16;
    localparam int MAX_DATA_W = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [DIV_WIDTH-1:0] cfg_baud_div;
    logic [3:0]           cfg_data_width;
    logic                 cfg_parity_en;
    logic                 cfg_parity_odd;
    logic                 cfg_stop2;
    logic                 tx;
    logic                 busy;
    logic                 frame_done;

    device1_tx_frame_controller_if #(.MAX_DATA_W(MAX_DATA_W)) char_if ();

    device1_tx_frame_controller #(
        .DIV_WIDTH  (DIV_WIDTH),
        .MAX_DATA_W (MAX_DATA_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_baud_div   (cfg_baud_div),
        .cfg_data_width (cfg_data_width),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .char_if        (char_if),
        .tx             (tx),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int acc_cyc     = 0;
    int done_cyc    = -1;
    int done_lat    = -1;
    int done_cnt    = 0;
    bit exp_q[$];
    bit log_q[$];

    // Expected line levels, one entry per clock, built from the frame rules.
    function automatic void push_frame(int div, int wcfg, bit pe, bit po, bit s2, logic [7:0] d);
        int d_eff;
        int w;
        int ones;
        bit lv[$];
        d_eff = (div == 0) ? 1 : div;
        w     = (wcfg < 5) ? 5 : ((wcfg > 8) ? 8 : wcfg);
        ones  = 0;
        lv.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            lv.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pe) lv.push_back(((ones % 2) == 1) ^ po);
        lv.push_back(1'b1);
        if (s2) lv.push_back(1'b1);
        foreach (lv[i]) begin
            for (int k = 0; k < d_eff; k++) exp_q.push_back(lv[i]);
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    // Check this cycle's outputs, advance the model across the coming posedge, then wait one clock.
    task automatic cycle();
        int sz;
        bit e_tx;
        bit acc;
        sz   = exp_q.size();
        e_tx = (sz > 0) ? exp_q[0] : 1'b1;
        chk("tx", 32'(tx), 32'(e_tx));
        chk("busy", 32'(busy), 32'(sz > 0));
        chk("tx_ready", 32'(char_if.tx_ready), 32'(sz <= 1));
        chk("frame_done", 32'(frame_done), 32'(sz == 1));
        log_q.push_back(tx);
        if (frame_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            done_lat = cyc - acc_cyc;
        end
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            acc = (char_if.tx_valid === 1'b1) && (sz <= 1);
            if (sz > 0) void'(exp_q.pop_front());
            if (acc) begin
                push_frame(int'(cfg_baud_div), int'(cfg_data_width), cfg_parity_en,
                           cfg_parity_odd, cfg_stop2, char_if.tx_data);
                acc_cyc = cyc;
                $display("cyc %0d: accept data=%02h div=%0d w=%0d par=%0b odd=%0b stop2=%0b",
                         cyc, char_if.tx_data, cfg_baud_div, cfg_data_width,
                         cfg_parity_en, cfg_parity_odd, cfg_stop2);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_cfg(input int div, input int w, input bit pe, input bit po, input bit s2);
        cfg_baud_div   = DIV_WIDTH'(div);
        cfg_data_width = 4'(w);
        cfg_parity_en  = pe;
        cfg_parity_odd = po;
        cfg_stop2      = s2;
    endtask

    initial begin
        logic [9:0] t1_bits;
        int dc0;
        int t4_acc;
        t1_bits          = 10'b1010101010;
        char_if.tx_valid = 1'b0;
        char_if.tx_data  = '0;
        set_cfg(4, 8, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ready", 32'(char_if.tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        repeat (2) cycle();

        // 1: div=4, 8N1, 0x55
        dc0 = done_cnt;
        set_cfg(4, 8, 0, 0, 0);
        char_if.tx_data  = 8'h55;
        char_if.tx_valid = 1'b1;
        log_q.delete();
        cycle();
        char_if.tx_valid = 1'b0;
        repeat (42) cycle();
        chk("t1_latency", done_lat, 40);
        chk("t1_frames", done_cnt - dc0, 1);
        for (int i = 0; i < 40; i++) chk("t1_wave", 32'(log_q[i + 1]), 32'(t1_bits[i / 4]));

        // 2: div=3, 7 bits, even parity, 0xD3
        set_cfg(3, 7, 1, 0, 0);
        char_if.tx_data  = 8'hD3;
        char_if.tx_valid = 1'b1;
        cycle();
        char_if.tx_valid = 1'b0;
        repeat (32) cycle();
        chk("t2_latency", done_lat, 30);

        // 3: div=2, 8 bits, odd parity, two stop bits, 0x00
        set_cfg(2, 8, 1, 1, 1);
        char_if.tx_data  = 8'h00;
        char_if.tx_valid = 1'b1;
        cycle();
        char_if.tx_valid = 1'b0;
        repeat (26) cycle();
        chk("t3_latency", done_lat, 24);

        // 4: back-to-back 0xA5 then 0x3C
        dc0 = done_cnt;
        set_cfg(4, 8, 0, 0, 0);
        char_if.tx_data  = 8'hA5;
        char_if.tx_valid = 1'b1;
        cycle();
        t4_acc = acc_cyc;
        char_if.tx_data = 8'h3C;
        repeat (40) cycle();
        char_if.tx_valid = 1'b0;
        repeat (42) cycle();
        chk("t4_total", done_cyc - t4_acc, 80);
        chk("t4_frames", done_cnt - dc0, 2);

        // 5: reset pulse during data bit 3
        set_cfg(4, 8, 0, 0, 0);
        char_if.tx_data  = 8'hF0;
        char_if.tx_valid = 1'b1;
        cycle();
        char_if.tx_valid = 1'b0;
        repeat (17) cycle();
        dc0   = done_cnt;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("t5_tx", 32'(tx), 32'd1);
        chk("t5_ready", 32'(char_if.tx_ready), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        repeat (30) cycle();
        chk("t5_no_done", done_cnt, dc0);

        // 6: div=0 and width=2 clamp to 1 clock per bit and 5 data bits
        set_cfg(0, 2, 0, 0, 0);
        char_if.tx_data  = 8'h1F;
        char_if.tx_valid = 1'b1;
        cycle();
        char_if.tx_valid = 1'b0;
        repeat (9) cycle();
        chk("t6_latency", done_lat, 7);

        // 7: configuration scrambled right after accept
        set_cfg(3, 8, 0, 0, 0);
        char_if.tx_data  = 8'h96;
        char_if.tx_valid = 1'b1;
        cycle();
        char_if.tx_valid = 1'b0;
        set_cfg(7, 5, 1, 1, 1);
        char_if.tx_data = 8'hFF;
        repeat (32) cycle();
        chk("t7_latency", done_lat, 30);

        // Random traffic: cfg and data change every clock, occasional resets.
        repeat (3000) begin
            rst_n            = ($urandom_range(0, 499) != 0);
            char_if.tx_valid = ($urandom_range(0, 2) != 0);
            char_if.tx_data  = 8'($urandom);
            set_cfg($urandom_range(0, 5), $urandom_range(0, 15), 1'($urandom),
                    1'($urandom), 1'($urandom));
            cycle();
        end
        rst_n            = 1'b1;
        char_if.tx_valid = 1'b0;
        repeat (150) cycle();
        chk("drained_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
